// File: rtl/bit_deser_pkg.sv
// Shared types and constants for the bit deserializer.
// Optional parity support is enabled by defining BIT_DESER_PARITY_EN.
package bit_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

`ifdef BIT_DESER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/bit_deser_if.sv
// Serial input and word output bundle of the bit deserializer.
// o_parity_err exists only when BIT_DESER_PARITY_EN is defined.
interface bit_deser_if
    import bit_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             i_bit;
    logic             i_bit_valid;
    logic             i_frame_start;
    logic [WIDTH-1:0] o_word;
    logic             o_word_valid;
    logic             i_word_ready;
    logic             o_frame_err;
    logic             o_overrun;
`ifdef BIT_DESER_PARITY_EN
    logic             o_parity_err;
`endif

    // Word handshake: a word transfers on every rising edge where
    // o_word_valid and i_word_ready are both high; o_word is held stable
    // while o_word_valid is high and the transfer has not yet happened.
    modport slave (
`ifdef BIT_DESER_PARITY_EN
        output o_parity_err,
`endif
        input  i_bit, i_bit_valid, i_frame_start, i_word_ready,
        output o_word, o_word_valid, o_frame_err, o_overrun
    );

    modport master (
`ifdef BIT_DESER_PARITY_EN
        input  o_parity_err,
`endif
        output i_bit, i_bit_valid, i_frame_start, i_word_ready,
        input  o_word, o_word_valid, o_frame_err, o_overrun
    );

endinterface

// File: rtl/bit_deser_shift_reg.sv
// MSB-first shift register with bit counter; start reloads with one bit,
// clear empties it, count_done flags that the next shift is the last data bit.
module bit_deser_shift_reg
    import bit_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic             shift,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             count_done
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (start) begin
            sr_d  = {{(WIDTH-1){1'b0}}, bit_in};
            cnt_d = CW'(1);
        end else if (shift) begin
            sr_d  = {sr_q[WIDTH-2:0], bit_in};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign data       = sr_q;
    assign count_done = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_deserializer.sv
// Framed MSB-first serial-to-parallel converter with valid/ready word output.
// Define BIT_DESER_PARITY_EN to consume a trailing even-parity bit per word.
module bit_deserializer
    import bit_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    bit_deser_if.slave  bus,
    output state_e      o_dbg_state
);

    state_e           state_q, state_d;
    logic             sr_clear, sr_start, sr_shift, sr_done;
    logic [WIDTH-1:0] sr_data;
    logic             complete, frame_err_d, frame_err_q;
    logic [WIDTH-1:0] complete_word, word_q, word_d;
    logic             valid_q, valid_d, overrun_q, overrun_d;
    logic             qual, fstart;

    assign qual   = bus.i_bit_valid;
    assign fstart = bus.i_bit_valid & bus.i_frame_start;

    bit_deser_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (sr_clear),
        .start      (sr_start),
        .shift      (sr_shift),
        .bit_in     (bus.i_bit),
        .data       (sr_data),
        .count_done (sr_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fstart) state_d = SHIFT;
            SHIFT:   if (qual && !fstart && sr_done) state_d = PARITY_EN ? PARITY : IDLE;
            PARITY:  if (qual) state_d = fstart ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A frame start always wins, even on the bit that would finish a word.
    always_comb begin
        sr_clear    = 1'b0;
        sr_start    = 1'b0;
        sr_shift    = 1'b0;
        complete    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: sr_start = fstart;
            SHIFT: begin
                if (fstart) begin
                    sr_start    = 1'b1;
                    frame_err_d = 1'b1;
                end else if (qual && sr_done && !PARITY_EN) begin
                    complete = 1'b1;
                    sr_clear = 1'b1;
                end else if (qual) begin
                    sr_shift = 1'b1;
                end
            end
            PARITY: begin
                if (fstart) begin
                    sr_start    = 1'b1;
                    frame_err_d = 1'b1;
                end else if (qual) begin
                    complete = 1'b1;
                    sr_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // With parity the data is already fully shifted in; without it the
    // incoming bit is the word's LSB.
    assign complete_word = PARITY_EN ? sr_data : {sr_data[WIDTH-2:0], bus.i_bit};

`ifdef BIT_DESER_PARITY_EN
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q & ~bus.i_word_ready;
        overrun_d = overrun_q;
`ifdef BIT_DESER_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (complete) begin
            if (!valid_q || bus.i_word_ready) begin
                word_d  = complete_word;
                valid_d = 1'b1;
`ifdef BIT_DESER_PARITY_EN
                parity_err_d = (^sr_data) ^ bus.i_bit;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            word_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            word_q      <= word_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef BIT_DESER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.o_word       = word_q;
    assign bus.o_word_valid = valid_q;
    assign bus.o_overrun    = overrun_q;
    assign bus.o_frame_err  = frame_err_q;
`ifdef BIT_DESER_PARITY_EN
    assign bus.o_parity_err = parity_err_q;
`endif
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer (WIDTH = 8); inputs change on the
// falling edge and outputs are checked on the following falling edge.
module tb_bit_deserializer;
    import bit_deser_pkg::*;

    logic   i_clk = 1'b0;
    logic   i_rst_n = 1'b0;
    state_e dbg_state;
    int     n_cmp = 0;
    int     n_err = 0;
    int     fe_cnt = 0;
    int     wv_cnt = 0;

    bit_deser_if #(.WIDTH(8)) bus ();

    bit_deserializer #(.WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic fs, input logic b);
        bus.i_bit_valid   = v;
        bus.i_frame_start = fs;
        bus.i_bit         = b;
        @(negedge i_clk);
        if (bus.o_frame_err)  fe_cnt++;
        if (bus.o_word_valid) wv_cnt++;
    endtask

    // Sends bit indices lo..hi of d (index 0 = MSB, carries frame start);
    // a correct even-parity bit follows index 7 when parity is built in.
    task automatic send_bits(input logic [7:0] d, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps && i > lo) cyc(1'b0, 1'b1, ~d[7-i]);
            cyc(1'b1, 1'(i == 0), d[7-i]);
        end
`ifdef BIT_DESER_PARITY_EN
        if (hi == 7) cyc(1'b1, 1'b0, ^d);
`endif
    endtask

    initial begin
        bus.i_bit         = 1'b0;
        bus.i_bit_valid   = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_word_ready  = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("reset_word", bus.o_word, 32'h0);
        chk("reset_valid", bus.o_word_valid, 32'h0);
        chk("reset_overrun", bus.o_overrun, 32'h0);
        chk("reset_frame_err", bus.o_frame_err, 32'h0);
        chk("reset_state", dbg_state, IDLE);
        i_rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        chk("idle_ignores_bits", dbg_state, IDLE);

        // basic word
        fe_cnt = 0; wv_cnt = 0;
        send_bits(8'hB2, 0, 6, 1'b0);
        chk("basic_not_yet_valid", bus.o_word_valid, 32'h0);
        chk("basic_state_shift", dbg_state, SHIFT);
        send_bits(8'hB2, 7, 7, 1'b0);
        chk("basic_valid", bus.o_word_valid, 32'h1);
        chk("basic_word", bus.o_word, 32'hB2);
        cyc(1'b0, 1'b0, 1'b0);
        chk("basic_valid_drop", bus.o_word_valid, 32'h0);
        chk("basic_valid_cycles", wv_cnt, 32'd1);
        chk("basic_no_frame_err", fe_cnt, 32'd0);

        // gaps between qualified bits
        fe_cnt = 0;
        send_bits(8'hB2, 0, 7, 1'b1);
        chk("gaps_word", bus.o_word, 32'hB2);
        chk("gaps_valid", bus.o_word_valid, 32'h1);
        chk("gaps_no_frame_err", fe_cnt, 32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        // resync mid-word
        fe_cnt = 0; wv_cnt = 0;
        send_bits(8'hFF, 0, 2, 1'b0);
        chk("resync_pre_err", fe_cnt, 32'd0);
        send_bits(8'h5A, 0, 7, 1'b0);
        chk("resync_word", bus.o_word, 32'h5A);
        chk("resync_frame_err_count", fe_cnt, 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resync_single_word", wv_cnt, 32'd1);

        // frame start on the last data bit
        fe_cnt = 0; wv_cnt = 0;
        send_bits(8'h00, 0, 6, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("lastbit_no_word", bus.o_word_valid, 32'h0);
        chk("lastbit_frame_err", bus.o_frame_err, 32'h1);
        send_bits(8'h96, 1, 7, 1'b0);
        chk("lastbit_next_word", bus.o_word, 32'h96);
        chk("lastbit_err_count", fe_cnt, 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("lastbit_one_word", wv_cnt, 32'd1);

        // new word loads on the same edge the held word is accepted
        bus.i_word_ready = 1'b0;
        send_bits(8'h33, 0, 7, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("hold_valid", bus.o_word_valid, 32'h1);
        chk("hold_word", bus.o_word, 32'h33);
        send_bits(8'h44, 0, 6, 1'b0);
        bus.i_word_ready = 1'b1;
        send_bits(8'h44, 7, 7, 1'b0);
        chk("swap_word", bus.o_word, 32'h44);
        chk("swap_valid", bus.o_word_valid, 32'h1);
        chk("swap_no_overrun", bus.o_overrun, 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("swap_drained", bus.o_word_valid, 32'h0);

        // overrun
        bus.i_word_ready = 1'b0;
        send_bits(8'h11, 0, 7, 1'b0);
        chk("ovr_first_word", bus.o_word, 32'h11);
        send_bits(8'h22, 0, 7, 1'b0);
        chk("ovr_word_kept", bus.o_word, 32'h11);
        chk("ovr_flag", bus.o_overrun, 32'h1);
        chk("ovr_valid", bus.o_word_valid, 32'h1);
        bus.i_word_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("ovr_valid_drop", bus.o_word_valid, 32'h0);
        chk("ovr_sticky", bus.o_overrun, 32'h1);

        // reset mid-word, with a frame start presented during reset
        send_bits(8'hF0, 0, 3, 1'b0);
        i_rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_word", bus.o_word, 32'h0);
        chk("rst_valid", bus.o_word_valid, 32'h0);
        chk("rst_overrun", bus.o_overrun, 32'h0);
        chk("rst_frame_err", bus.o_frame_err, 32'h0);
        chk("rst_state", dbg_state, IDLE);
        i_rst_n = 1'b1;
        send_bits(8'hC3, 0, 7, 1'b0);
        chk("rst_after_word", bus.o_word, 32'hC3);
        chk("rst_after_valid", bus.o_word_valid, 32'h1);
        cyc(1'b0, 1'b0, 1'b0);

`ifdef BIT_DESER_PARITY_EN
        send_bits(8'hB2, 0, 6, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("par_waits_for_parity", bus.o_word_valid, 32'h0);
        chk("par_state", dbg_state, PARITY);
        cyc(1'b1, 1'b0, 1'b0);
        chk("par_good_word", bus.o_word, 32'hB2);
        chk("par_good_flag", bus.o_parity_err, 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        send_bits(8'hB2, 0, 6, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("par_bad_word", bus.o_word, 32'hB2);
        chk("par_bad_valid", bus.o_word_valid, 32'h1);
        chk("par_bad_flag", bus.o_parity_err, 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Serial-to-parallel stage that consumes the registered single-bit stream produced by the upstream D flip-flop stage. It assembles framed, MSB-first bit sequences into WIDTH-bit words and presents them on a valid/ready output handshake. It also flags framing errors and dropped words.

## Interface
- WIDTH, 8: data bits per word, legal range 2–32.
- i_clk  in  1  single clock; all logic is on its rising edge.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_bit  in  1  serial data bit, driven by the upstream flip-flop Q output.
- i_bit_valid  in  1  qualifies i_bit for this cycle.
- i_frame_start  in  1  marks the qualified bit as bit 0 (MSB) of a new word; ignored unless i_bit_valid is high.
- o_word  out  WIDTH  assembled word, MSB = first bit received.
- o_word_valid  out  1  o_word holds an undelivered word.
- i_word_ready  in  1  downstream accepts o_word when high together with o_word_valid.
- o_frame_err  out  1  one-cycle pulse when a frame start arrives mid-word.
- o_overrun  out  1  sticky flag: a completed word was dropped.
- o_parity_err  out  1  present only with BIT_DESER_PARITY_EN; see Configuration.

## Operation
- **States**:
  - IDLE: qualified bits without frame start are ignored.
  - SHIFT: collecting data bits.
  - PARITY: only with BIT_DESER_PARITY_EN.
- **IDLE → SHIFT**: on i_bit_valid && i_frame_start. That bit shifts in as bit 0, and count becomes 1.
- **SHIFT, qualified bit without frame start**:
  - shift_reg <= {shift_reg[WIDTH-2:0], i_bit}; count++.
  - On the WIDTH-th bit, the word is complete. Without the parity feature, state → IDLE; with it, state → PARITY.
- **SHIFT, qualified bit with frame start (resync)**:
  - Partial word discarded; the bit becomes the new bit 0 and count = 1.
  - o_frame_err pulses for one cycle.
  - o_overrun is unaffected.
- **Frame start on the last data bit**: resync rule wins; no word is produced.
- **Unqualified cycles** (i_bit_valid low): no state or count change, in any state.
- **Word completion**: shift register contents are loaded into the output register.
  - If o_word_valid is low, or i_word_ready is high that same cycle: o_word is loaded and o_word_valid is high.
  - Else: the new word is dropped, o_word is unchanged, and o_overrun is set. It stays set until reset.
- **Handshake**:
  - o_word_valid falls after an edge where o_word_valid && i_word_ready, unless a new word loads on that same edge.
  - o_word is stable while o_word_valid is high.
- **Counter**: width $clog2(WIDTH+1); wraps to 0 on every return to IDLE.

## Timing
- **Latency**: o_word_valid rises on the edge that samples the final bit (data, or parity when enabled). It is visible the following cycle.
- **Throughput**: back-to-back frames allowed. A frame start may arrive on the cycle immediately after completion.
- **Reset**: i_rst_n low at a rising edge forces, on that edge:
  - state IDLE, count 0, shift_reg 0;
  - o_word 0, o_word_valid 0, o_frame_err 0, o_overrun 0, o_parity_err 0.
- **Reset mid-word**: the partial word is discarded; the first frame after release starts cleanly.
- **Reset precedence**: reset overrides all simultaneous inputs.
- **Outputs**: all are registered; no combinational input-to-output paths.

## Configuration
- **BIT_DESER_PARITY_EN defined**:
  - After WIDTH data bits, one further qualified bit is consumed in PARITY as an even-parity bit over the data.
  - o_parity_err is loaded together with o_word and is high when parity mismatches. The word is still delivered.
  - A frame start during PARITY is treated as a resync: o_frame_err pulses and no word is produced.
- **BIT_DESER_PARITY_EN not defined**: no PARITY state, no o_parity_err port, and words complete after WIDTH bits.

## Structure
- **Shared package bit_deser_pkg**:
  - state enum (IDLE, SHIFT, PARITY);
  - default-width localparam;
  - parity-mode constant.
- **Sub-module bit_deser_shift_reg**: the shift register plus bit counter, with shift/clear/count-done signals. The top level holds the FSM, output register and flags.

## Test plan
Bench uses WIDTH = 8.
- **Basic word**: frame start with bits 1,0,1,1,0,0,1,0 on consecutive cycles, ready high → o_word = 8'hB2, o_word_valid high for exactly one cycle, one cycle after the last bit's edge.
- **Gaps**: same bits with i_bit_valid low on alternate cycles → o_word = 8'hB2; no frame_err.
- **Resync**: frame start, 3 bits, then a frame start plus 8'h5A → one o_frame_err pulse and a single word 8'h5A.
- **Overrun**: ready low; send 8'h11 then 8'h22 → o_word stays 8'h11 and o_overrun is set. After ready goes high, o_word_valid drops and o_overrun stays 1.
- **Reset mid-word**: 4 bits, then i_rst_n low for one cycle → all outputs 0. A following frame 8'hC3 delivers 8'hC3.
- **Parity (macro defined)**: 8'hB2 with parity bit 0 → o_parity_err 0. Same data with parity bit 1 → o_word 8'hB2 with o_parity_err 1.
